// File: rtl/dctr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dctr_pkg
// Description : Shared types and default constants for the dctr_timer
//               loadable down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package dctr_pkg;

  // Default counter / load-value width in bits.
  localparam int DCTR_WIDTH    = 6;
  // Default enabled cycles per decrement (prescaler builds only).
  localparam int DCTR_PRESCALE = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dctr_state_e;

endpackage : dctr_pkg
`default_nettype wire

// File: rtl/dctr_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : dctr_prescaler
// Description : Counts enabled cycles 0..PRESCALE-1 and issues a one-cycle
//               tick on the enabled cycle that wraps the count back to 0.
//               A synchronous clear restarts the phase.
// Revision    : 1.0 - initial release
// ============================================================================
module dctr_prescaler
  import dctr_pkg::*;
#(
  parameter int PRESCALE = DCTR_PRESCALE
) (
  input  logic clk,
  input  logic clr,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next phase: clear wins, otherwise advance on enable and wrap at LAST.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Phase register with asynchronous reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule : dctr_prescaler
`default_nettype wire

// File: rtl/dctr_timer.sv
`default_nettype none
// ============================================================================
// Module      : dctr_timer
// Description : Loadable down-counter/timer. Counts load_val down to zero on
//               enabled cycles, then pulses done for one cycle. Optional
//               auto-reload gives periodic ticks.
//               Build option: define DCTR_PRESCALE_EN to require PRESCALE
//               enabled cycles per decrement.
// Revision    : 1.0 - initial release
// ============================================================================
module dctr_timer
  import dctr_pkg::*;
#(
  parameter int WIDTH    = DCTR_WIDTH,
  parameter int PRESCALE = DCTR_PRESCALE
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             T,
  input  logic             stop,
  input  logic             reload,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  dctr_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [WIDTH-1:0] rld_q,   rld_d;
  logic             done_q,  done_d;
  logic             act;

`ifdef DCTR_PRESCALE_EN
  logic pre_clear;
  assign pre_clear = (state_q != RUN) | start | stop;

  dctr_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .clr     (clr),
    .clear_i (pre_clear),
    .en_i    (T),
    .tick_o  (act)
  );
`else
  // PRESCALE only matters when the prescaler is built.
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);
  assign act = T;
`endif

  // Next-state, count and done decode; stop beats start beats counting.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    if (state_q == RUN && stop) begin
      state_d = IDLE;
    end else if (start) begin
      if (load_val != '0) begin
        out_d   = load_val;
        rld_d   = load_val;
        state_d = RUN;
      end else begin
        out_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end else if (state_q == RUN && act) begin
      if (out_q > WIDTH'(1)) begin
        out_d = out_q - 1'b1;
      end else begin
        done_d = 1'b1;
        if (reload) begin
          out_d = rld_q;
        end else begin
          out_d   = '0;
          state_d = IDLE;
        end
      end
    end
  end

  // State, count, reload and done registers with asynchronous reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      out_q   <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule : dctr_timer
`default_nettype wire

// File: tb/tb_dctr_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dctr_timer
// Description : Directed self-checking bench for dctr_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dctr_timer;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             T;
  logic             stop;
  logic             reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  dctr_timer #(
    .WIDTH    (WIDTH),
    .PRESCALE (4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .load_val (load_val),
    .T        (T),
    .stop     (stop),
    .reload   (reload),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input int e_out, input int e_busy,
                      input int e_done);
    chk({tag, ".out"},  int'(out),  e_out);
    chk({tag, ".busy"}, int'(busy), e_busy);
    chk({tag, ".done"}, int'(done), e_done);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; load_val = '0; T = 1'b0; stop = 1'b0;
    reload = 1'b0;
    #3;
    chk3("reset", 0, 0, 0);
    step();
    clr = 1'b0;

    // Basic countdown of 5.
    start = 1'b1; load_val = 6'd5;
    step();
    chk3("basic.load", 5, 1, 0);
    start = 1'b0; T = 1'b1;
    for (int k = 4; k >= 1; k--) begin
      step();
      chk3($sformatf("basic.cnt%0d", k), k, 1, 0);
    end
    step();
    chk3("basic.term", 0, 0, 1);
    step();
    chk3("basic.after", 0, 0, 0);

    // Zero load.
    T = 1'b0; start = 1'b1; load_val = 6'd0;
    step();
    chk3("zero.done", 0, 0, 1);
    start = 1'b0;
    step();
    chk3("zero.after", 0, 0, 0);

    // Gated enable, then stop beating start.
    start = 1'b1; load_val = 6'd4;
    step();
    chk3("gate.load", 4, 1, 0);
    start = 1'b0;
    T = 1'b1; step(); chk3("gate.t1", 3, 1, 0);
    T = 1'b0; step(); chk3("gate.t0a", 3, 1, 0);
    step();           chk3("gate.t0b", 3, 1, 0);
    T = 1'b1; step(); chk3("gate.t1b", 2, 1, 0);
    T = 1'b0; stop = 1'b1; start = 1'b1; load_val = 6'd9;
    step();
    chk3("stop.win", 2, 0, 0);
    stop = 1'b0; start = 1'b0;
    step();
    chk3("stop.after", 2, 0, 0);

    // Auto-reload with period 3.
    reload = 1'b1; start = 1'b1; load_val = 6'd3;
    step();
    chk3("rld.load", 3, 1, 0);
    start = 1'b0; T = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk3($sformatf("rld.c%0d", c), (c % 3 == 0) ? 3 : 3 - (c % 3), 1,
           (c % 3 == 0) ? 1 : 0);
    end
    T = 1'b0; stop = 1'b1;
    step();
    chk3("rld.stop", 3, 0, 0);
    stop = 1'b0; reload = 1'b0;

    // Max load, then asynchronous reset mid-run.
    start = 1'b1; load_val = 6'd63;
    step();
    chk3("max.load", 63, 1, 0);
    start = 1'b0; T = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk3("max.cnt10", 53, 1, 0);
    #2 clr = 1'b1;
    #1 chk3("areset.run", 0, 0, 0);
    #2 clr = 1'b0;
    step();
    chk3("idle.Tignored", 0, 0, 0);

    // Reset landing on a done pulse.
    start = 1'b1; load_val = 6'd1;
    step();
    chk3("one.load", 1, 1, 0);
    start = 1'b0;
    step();
    chk3("one.term", 0, 0, 1);
    #2 clr = 1'b1;
    #1 chk3("areset.done", 0, 0, 0);
    #2 clr = 1'b0;
    T = 1'b0;
    step();

`ifdef DCTR_PRESCALE_EN
    // Prescale of 4: decrement after enabled cycles 4 and 8.
    start = 1'b1; load_val = 6'd2;
    step();
    chk3("pre.load", 2, 1, 0);
    start = 1'b0; T = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk3($sformatf("pre.c%0d", c), (c < 4) ? 2 : (c < 8) ? 1 : 0,
           (c < 8) ? 1 : 0, (c == 8) ? 1 : 0);
    end
    // Restart mid-phase resets the 4-cycle phase.
    start = 1'b1; load_val = 6'd2;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1;
    step();
    chk3("pre.restart", 2, 1, 0);
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk3($sformatf("pre.rs%0d", c), (c < 4) ? 2 : 1, 1, 0);
    end
    T = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dctr_timer
`default_nettype wire
